// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the sram-like bus bridge.
// State encoding, bus size codes and byte-count to size conversion.
package sram_like_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  function automatic logic [1:0] log2_bytes(input int n);
    if (n >= 8) return SZ_DWORD;
    if (n >= 4) return SZ_WORD;
    if (n >= 2) return SZ_HALF;
    return SZ_BYTE;
  endfunction

endpackage

// File: rtl/strb_decode.sv
// Write-strobe decoder: byte mask to bus size, byte offset and legality.
// Legal masks are contiguous, power-of-two sized and naturally aligned.
module strb_decode
  import sram_like_pkg::*;
#(
  parameter int STRB_W = 4
) (
  input  logic [STRB_W-1:0]         wen_i,
  output logic [1:0]                size_o,
  output logic [$clog2(STRB_W)-1:0] off_o,
  output logic                      illegal_o
);

  localparam int OFF_W = $clog2(STRB_W);

  int   pc;
  int   lo;
  logic ok;

  always_comb begin
    pc        = 0;
    lo        = STRB_W;
    ok        = 1'b1;
    illegal_o = 1'b0;
    off_o     = '0;
    for (int i = 0; i < STRB_W; i++) begin
      if (wen_i[i]) begin
        pc = pc + 1;
        if (lo == STRB_W) lo = i;
      end
    end
    // every byte between the lowest set bit and lo+pc must be set
    for (int i = 0; i < STRB_W; i++) begin
      if (wen_i[i] != ((i >= lo) && (i < lo + pc))) ok = 1'b0;
    end
    if (pc != 0) begin
      off_o     = OFF_W'(lo);
      illegal_o = !ok
               || ((pc & (pc - 1)) != 0)
               || ((lo % pc) != 0);
    end
    size_o = log2_bytes(pc);
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridge from a single-cycle SRAM-style port to the split sram-like bus.
// Holds the request stable until addr_ok and drains cancelled transfers.
module sram_like_bridge
  import sram_like_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_en,
  input  logic [STRB_W-1:0] sram_wen,
  input  logic [1:0]        sram_size,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  output logic              sram_stall,
  output logic              sram_err,
  input  logic              flush,
  input  logic              longest_stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              addr_ok,
  input  logic              data_ok
);

  localparam int         OFF_W   = $clog2(STRB_W);
  localparam logic [1:0] SZ_FULL = log2_bytes(STRB_W);

  state_t            state_q, state_d;
  logic              cancel_q, cancel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        dec_size;
  logic [OFF_W-1:0]  dec_off;
  logic              dec_ill;
  logic              wr_live;
  logic [1:0]        size_live;
  logic [ADDR_W-1:0] addr_live;
  logic              issue;
  logic              drop;

  strb_decode #(
    .STRB_W(STRB_W)
  ) u_dec (
    .wen_i    (sram_wen),
    .size_o   (dec_size),
    .off_o    (dec_off),
    .illegal_o(dec_ill)
  );

  // illegal masks fall back to a full-width aligned write
  always_comb begin
    wr_live   = |sram_wen;
    size_live = sram_size;
    addr_live = sram_addr;
    if (wr_live) begin
      size_live = dec_ill ? SZ_FULL : dec_size;
      addr_live = {sram_addr[ADDR_W-1:OFF_W],
                   dec_ill ? {OFF_W{1'b0}} : dec_off};
    end
  end

  assign issue = (state_q == IDLE) & sram_en & ~flush;
  assign drop  = cancel_q | flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
      if (issue) begin
        wr_q    <= wr_live;
        size_q  <= size_live;
        addr_q  <= addr_live;
        wdata_q <= sram_wdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    unique case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (issue) begin
          if (addr_ok & data_ok) state_d = DONE;
          else if (addr_ok)      state_d = WAIT;
          else                   state_d = REQ;
        end
      end
      REQ: begin
        cancel_d = drop;
        if (addr_ok & data_ok) begin
          state_d  = drop ? IDLE : DONE;
          cancel_d = 1'b0;
        end else if (addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cancel_d = drop;
        if (data_ok) begin
          state_d  = drop ? IDLE : DONE;
          cancel_d = 1'b0;
        end
      end
      DONE: begin
        cancel_d = 1'b0;
        if (~longest_stall | flush) state_d = IDLE;
      end
    endcase
    rdata_d = ((state_d == DONE) && (state_q != DONE)) ? rdata : rdata_q;
  end

  // IDLE presents the live request; later states replay the latched copy
  always_comb begin
    wr       = wr_q;
    size     = size_q;
    addr     = addr_q;
    wdata    = wdata_q;
    req      = 1'b0;
    sram_err = 1'b0;
    if (state_q == IDLE) begin
      wr    = wr_live;
      size  = size_live;
      addr  = addr_live;
      wdata = sram_wdata;
    end
    if (!rst) begin
      req      = issue | (state_q == REQ);
      sram_err = issue & wr_live & dec_ill;
    end
    sram_stall = ~rst & ((sram_en & (state_q != DONE)) | cancel_q);
    sram_rdata = rdata_q;
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Scoreboard bench for sram_like_bridge with a scripted bus slave.
// Bus requests and pipeline completions are checked by a monitor.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_stall;
  logic        sram_err;
  logic        flush;
  logic        longest_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  always #5 clk = ~clk;

  sram_like_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .sram_en      (sram_en),
    .sram_wen     (sram_wen),
    .sram_size    (sram_size),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_stall   (sram_stall),
    .sram_err     (sram_err),
    .flush        (flush),
    .longest_stall(longest_stall),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok)
  );

  typedef logic [66:0] bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  int          n_chk    = 0;
  int          n_fail   = 0;
  int          err_seen = 0;
  logic [31:0] last_rd  = '0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bus acceptances and pipeline completions
  always @(negedge clk) begin
    if (req && addr_ok) begin
      if (bus_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL bus_unexpected: got addr %0h expected none", addr);
      end else begin
        check("bus_req", {wr, size, addr, wdata}, bus_q.pop_front());
      end
    end
    if (!rst && sram_en && !sram_stall && !longest_stall) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_unexpected: got %0h expected none",
                 sram_rdata);
      end else begin
        check("pipe_rdata", sram_rdata, rd_q.pop_front());
      end
    end
    if (sram_err) err_seen++;
  end

  task automatic xfer(input logic [3:0] w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int ta, input int td, input logic [31:0] rd,
                      input logic [1:0] esz, input logic [31:0] ea,
                      input logic eerr);
    bus_q.push_back({|w, esz, ea, wd});
    rd_q.push_back(rd);
    sram_en    = 1'b1;
    sram_wen   = w;
    sram_size  = sz;
    sram_addr  = a;
    sram_wdata = wd;
    for (int c = 0; c <= td; c++) begin
      addr_ok = (c == ta);
      data_ok = (c == td);
      rdata   = (c == td) ? rd : 32'h0BAD_0BAD;
      #1;
      check("req", req, c <= ta);
      check("stall", sram_stall, 1'b1);
      check("err", sram_err, eerr && (c == 0));
      step();
    end
    addr_ok = 1'b0;
    data_ok = 1'b0;
    #1;
    check("done_stall", sram_stall, 1'b0);
    check("done_rdata", sram_rdata, rd);
    step();
    sram_en  = 1'b0;
    sram_wen = '0;
    last_rd  = rd;
  endtask

  initial begin
    rst           = 1'b1;
    sram_en       = 1'b0;
    sram_wen      = '0;
    sram_size     = '0;
    sram_addr     = '0;
    sram_wdata    = '0;
    flush         = 1'b0;
    longest_stall = 1'b0;
    rdata         = '0;
    addr_ok       = 1'b0;
    data_ok       = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_req", req, 1'b0);
    check("rst_stall", sram_stall, 1'b0);
    check("rst_err", sram_err, 1'b0);
    check("rst_rdata", sram_rdata, 32'h0);

    // read with separated handshakes, then writes of each legal shape
    xfer(4'b0000, 2'd2, 32'h1000_0004, 32'h0, 2, 4, 32'hDEAD_BEEF,
         2'd2, 32'h1000_0004, 1'b0);
    xfer(4'b0100, 2'd3, 32'h2000_0000, 32'h1122_3344, 0, 1, 32'h0,
         2'd0, 32'h2000_0002, 1'b0);
    xfer(4'b1000, 2'd3, 32'h2000_0000, 32'h5566_7788, 1, 1, 32'h1,
         2'd0, 32'h2000_0003, 1'b0);
    xfer(4'b1100, 2'd0, 32'h2000_0010, 32'hAABB_CCDD, 1, 2, 32'h2,
         2'd1, 32'h2000_0012, 1'b0);
    xfer(4'b0011, 2'd0, 32'h2000_0010, 32'h0102_0304, 0, 0, 32'h3,
         2'd1, 32'h2000_0010, 1'b0);
    xfer(4'b1111, 2'd0, 32'h3000_0008, 32'hFFEE_DDCC, 0, 2, 32'h4,
         2'd2, 32'h3000_0008, 1'b0);
    // illegal masks: gap, misaligned half, three bytes
    xfer(4'b0101, 2'd0, 32'h2000_0007, 32'h1357_9BDF, 0, 1, 32'h5,
         2'd2, 32'h2000_0004, 1'b1);
    xfer(4'b0110, 2'd0, 32'h2000_0001, 32'h2468_ACE0, 1, 1, 32'h6,
         2'd2, 32'h2000_0000, 1'b1);
    xfer(4'b0111, 2'd0, 32'h2000_0002, 32'h0F0F_0F0F, 0, 0, 32'h7,
         2'd2, 32'h2000_0000, 1'b1);
    // same-cycle handshakes on a byte read, address passes unchanged
    xfer(4'b0000, 2'd0, 32'h4000_0003, 32'h0, 0, 0, 32'h0000_00A5,
         2'd0, 32'h4000_0003, 1'b0);

    // flush while idle suppresses the request
    sram_en   = 1'b1;
    sram_addr = 32'h4400_0000;
    flush     = 1'b1;
    #1;
    check("flush_idle_req", req, 1'b0);
    step();
    flush   = 1'b0;
    sram_en = 1'b0;
    step();

    // flush in WAIT: response discarded, stall held through the drain
    bus_q.push_back({1'b0, 2'd2, 32'h5000_0000, 32'h0});
    sram_en   = 1'b1;
    sram_wen  = '0;
    sram_size = 2'd2;
    sram_addr = 32'h5000_0000;
    addr_ok   = 1'b1;
    step();
    addr_ok = 1'b0;
    flush   = 1'b1;
    #1;
    check("drain_stall0", sram_stall, 1'b1);
    step();
    flush = 1'b0;
    #1;
    check("drain_stall1", sram_stall, 1'b1);
    check("drain_req", req, 1'b0);
    step();
    data_ok = 1'b1;
    rdata   = 32'h0000_1234;
    #1;
    check("drain_stall2", sram_stall, 1'b1);
    step();
    data_ok = 1'b0;
    check("drain_rdata", sram_rdata, last_rd);
    xfer(4'b0000, 2'd2, 32'h6000_0000, 32'h0, 0, 1, 32'h6666_0000,
         2'd2, 32'h6000_0000, 1'b0);

    // longest_stall holds DONE with sram_en high
    bus_q.push_back({1'b0, 2'd2, 32'h7000_0000, 32'h0});
    rd_q.push_back(32'hCAFE_F00D);
    sram_en   = 1'b1;
    sram_wen  = '0;
    sram_size = 2'd2;
    sram_addr = 32'h7000_0000;
    addr_ok   = 1'b1;
    data_ok   = 1'b1;
    rdata     = 32'hCAFE_F00D;
    step();
    addr_ok       = 1'b0;
    data_ok       = 1'b0;
    rdata         = 32'h0BAD_0BAD;
    longest_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ls_req", req, 1'b0);
      check("ls_stall", sram_stall, 1'b0);
      check("ls_rdata", sram_rdata, 32'hCAFE_F00D);
      step();
    end
    longest_stall = 1'b0;
    #1;
    check("ls_release_req", req, 1'b0);
    step();
    last_rd = 32'hCAFE_F00D;
    xfer(4'b0000, 2'd1, 32'h7000_0102, 32'h0, 1, 1, 32'h0000_BEEF,
         2'd1, 32'h7000_0102, 1'b0);

    // reset in the middle of WAIT
    bus_q.push_back({1'b0, 2'd2, 32'h8000_0000, 32'h0});
    sram_en   = 1'b1;
    sram_size = 2'd2;
    sram_addr = 32'h8000_0000;
    addr_ok   = 1'b1;
    step();
    addr_ok = 1'b0;
    sram_en = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_req", req, 1'b0);
    check("mid_rst_stall", sram_stall, 1'b0);
    check("mid_rst_err", sram_err, 1'b0);
    check("mid_rst_rdata", sram_rdata, 32'h0);
    step();
    xfer(4'b0000, 2'd2, 32'h9000_0010, 32'h0, 0, 2, 32'h9999_0001,
         2'd2, 32'h9000_0010, 1'b0);

    step();
    step();
    check("err_pulses", err_seen, 3);
    check("bus_q_left", bus_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
